// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: widths,
// address/instruction types, address field positions and FSM encodings.
package icache_direct_pkg;

  localparam int ICACHE_ADDR_WIDTH  = 32;
  localparam int ICACHE_INS_WIDTH   = 32;
  localparam int ICACHE_INDEX_WIDTH = 8;
  localparam int ICACHE_TAG_WIDTH   = ICACHE_ADDR_WIDTH - ICACHE_INDEX_WIDTH - 2;

  // Field positions inside a pc for the default geometry.
  localparam int ICACHE_INDEX_LSB = 2;
  localparam int ICACHE_INDEX_MSB = ICACHE_INDEX_WIDTH + 1;
  localparam int ICACHE_TAG_LSB   = ICACHE_INDEX_WIDTH + 2;
  localparam int ICACHE_TAG_MSB   = ICACHE_ADDR_WIDTH - 1;

  typedef logic [ICACHE_ADDR_WIDTH-1:0] addr_t;
  typedef logic [ICACHE_INS_WIDTH-1:0]  ins_t;

  // Controller states (2-bit encodings).
  localparam logic [1:0] ICACHE_IDLE = 2'd0;
  localparam logic [1:0] ICACHE_MISS = 2'd1;
  localparam logic [1:0] ICACHE_RESP = 2'd2;

  // Word-align an address before it goes out to memory.
  function automatic addr_t word_align(input addr_t a);
    return {a[ICACHE_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag + data storage for the direct-mapped cache. Writes are synchronous,
// reads are combinational so a hit can be resolved in the request cycle.
// Valid bits live in the parent so reset can clear them in one cycle.
module icache_array #(
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH   = 22,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [TAG_WIDTH-1:0]  tags  [LINES];
  logic [DATA_WIDTH-1:0] words [LINES];

  // Line fill: overwrite tag and word of the addressed line unconditionally.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_tag  = tags[rd_index];
  assign rd_data = words[rd_index];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher
// and the memory controller. Hits answer one cycle after the request;
// misses hold a level request to memory until the word returns, fill the
// line and then answer. A fetcher drop aborts anything in flight.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int ADDR_WIDTH  = ICACHE_ADDR_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  // fetcher side
  input  logic [ADDR_WIDTH-1:0]       pc_from_if,
  input  logic                        ena_from_if,
  input  logic                        drop_flag_from_if,
  output logic                        ok_flag_to_if,
  output logic [ICACHE_INS_WIDTH-1:0] inst_to_if,
  // memory controller side
  output logic [ADDR_WIDTH-1:0]       pc_to_mc,
  output logic                        ena_to_mc,
  output logic                        drop_flag_to_mc,
  input  logic                        ok_flag_from_mc,
  input  logic [ICACHE_INS_WIDTH-1:0] inst_from_mc
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int LINES     = 1 << INDEX_WIDTH;

  logic [1:0]                  state;
  logic [LINES-1:0]            valid;

  logic [INDEX_WIDTH-1:0]      rd_index;
  logic [TAG_WIDTH-1:0]        pc_tag;
  logic [TAG_WIDTH-1:0]        line_tag;
  logic [ICACHE_INS_WIDTH-1:0] line_data;
  logic                        hit;

  logic [INDEX_WIDTH-1:0]      wr_index;
  logic [TAG_WIDTH-1:0]        wr_tag;
  logic                        fill;

  // Byte-offset bits of the pc carry no information for word fetches.
  logic                        unused_pc_bits;
  assign unused_pc_bits = ^pc_from_if[1:0];

  // Lookup side decodes the live fetch address.
  assign rd_index = pc_from_if[INDEX_WIDTH+1:2];
  assign pc_tag   = pc_from_if[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign hit      = valid[rd_index] && (line_tag == pc_tag);

  // The outstanding miss address is held in pc_to_mc, so the fill side
  // decodes it directly instead of keeping a separate copy.
  assign wr_index = pc_to_mc[INDEX_WIDTH+1:2];
  assign wr_tag   = pc_to_mc[ADDR_WIDTH-1:INDEX_WIDTH+2];

  // A returning word is written only if nothing aborts it this cycle.
  assign fill = rdy && !rst && !drop_flag_from_if &&
                (state == ICACHE_MISS) && ok_flag_from_mc;

  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH),
    .DATA_WIDTH  (ICACHE_INS_WIDTH)
  ) u_array (
    .clk      (clk),
    .we       (fill),
    .wr_index (wr_index),
    .wr_tag   (wr_tag),
    .wr_data  (inst_from_mc),
    .rd_index (rd_index),
    .rd_tag   (line_tag),
    .rd_data  (line_data)
  );

  // Controller: IDLE looks up, MISS waits on memory, RESP holds the
  // one-cycle answer while the fetcher moves its pc. Drop beats everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ICACHE_IDLE;
      valid           <= '0;
      ok_flag_to_if   <= 1'b0;
      inst_to_if      <= '0;
      pc_to_mc        <= '0;
      ena_to_mc       <= 1'b0;
      drop_flag_to_mc <= 1'b0;
    end else if (rdy) begin
      ok_flag_to_if   <= 1'b0;
      drop_flag_to_mc <= 1'b0;
      if (drop_flag_from_if) begin
        state           <= ICACHE_IDLE;
        ena_to_mc       <= 1'b0;
        drop_flag_to_mc <= (state == ICACHE_MISS);
      end else begin
        case (state)
          ICACHE_IDLE: begin
            if (ena_from_if) begin
              if (hit) begin
                ok_flag_to_if <= 1'b1;
                inst_to_if    <= line_data;
                state         <= ICACHE_RESP;
              end else begin
                ena_to_mc <= 1'b1;
                pc_to_mc  <= {pc_from_if[ADDR_WIDTH-1:2], 2'b00};
                state     <= ICACHE_MISS;
              end
            end
          end
          ICACHE_MISS: begin
            if (ok_flag_from_mc) begin
              valid[wr_index] <= 1'b1;
              ok_flag_to_if   <= 1'b1;
              inst_to_if      <= inst_from_mc;
              ena_to_mc       <= 1'b0;
              state           <= ICACHE_RESP;
            end
          end
          ICACHE_RESP: state <= ICACHE_IDLE;
          default:     state <= ICACHE_IDLE;
        endcase
      end
    end
  end

  // The answer to the fetcher and the request to memory are exclusive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ok_flag_to_if && ena_to_mc));
    end
  end

endmodule
